// File: rtl/adc_12bit_spi_pkg.sv
// rtl/adc_12bit_spi_pkg.sv - shared state encoding and frame constants for the ADC SPI reader
package adc_12bit_spi_pkg;

  // State encoding is visible on debug_states, so the values are fixed
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SETUP    = 4'd1,
    ST_SHIFT_HI = 4'd2,
    ST_SHIFT_LO = 4'd3,
    ST_HOLD     = 4'd4
  } state_t;

  localparam int DATA_BITS = 12;
  // Width of the bit counter and of the timing counter load values
  localparam int CNT_W = 8;

  // Total sck rises per frame: discarded lead bits followed by the data word
  function automatic int frame_bits(input int lead_bits);
    return lead_bits + DATA_BITS;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - loadable half-period counter producing a tick every SCK_DIV cycles
module spi_sck_gen #(
  parameter int SCK_DIV = 3,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  localparam logic [W-1:0] RELOAD = W'(SCK_DIV - 1);

  logic [W-1:0] cnt;

  // A load sets the next tick load_val cycles out; afterwards it free-runs at SCK_DIV
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/adc_12bit_spi.sv
// rtl/adc_12bit_spi.sv - SPI master reading one 12-bit ADC conversion per frame
module adc_12bit_spi
  import adc_12bit_spi_pkg::*;
#(
  parameter int SCK_DIV   = 3,
  parameter int CS_SETUP  = 3,
  parameter int CS_IDLE   = 6,
  parameter int LEAD_BITS = 2
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic        start,
  input  logic        sdi,
  output logic        cs,
  output logic        sck,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic [3:0]  debug_states
);

  localparam int FRAME_BITS = frame_bits(LEAD_BITS);
  // HOLD needs at least one cycle to exist as a state
  localparam int HOLD_CYC   = (CS_IDLE < 1) ? 1 : CS_IDLE;

  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_BITS);

  state_t            state, state_n;
  logic              cs_n, sck_n, valid_n, capture;
  logic [CNT_W-1:0]  bits, bits_n;
  logic [11:0]       shreg, shreg_n, sample_n;
  logic              gen_load, tick;
  logic [CNT_W-1:0]  gen_val;

  spi_sck_gen #(
    .SCK_DIV (SCK_DIV),
    .W       (CNT_W)
  ) u_sck_gen (
    .clk      (clk12MHz),
    .rst      (rst),
    .load     (gen_load),
    .load_val (gen_val),
    .tick     (tick)
  );

  // Next-state, pin and datapath decisions; every sck 0->1 edge is also the sdi sampling edge
  always_comb begin
    state_n  = state;
    cs_n     = cs;
    sck_n    = sck;
    bits_n   = bits;
    shreg_n  = shreg;
    sample_n = sample;
    valid_n  = 1'b0;
    capture  = 1'b0;
    gen_load = 1'b0;
    gen_val  = SETUP_LOAD;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n  = ST_SETUP;
          cs_n     = 1'b0;
          bits_n   = FRAME_LOAD;
          gen_load = 1'b1;
          gen_val  = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_n = ST_SHIFT_HI;
          sck_n   = 1'b1;
          capture = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (tick) begin
          state_n = ST_SHIFT_LO;
          sck_n   = 1'b0;
        end
      end
      ST_SHIFT_LO: begin
        if (tick) begin
          if (bits != '0) begin
            state_n = ST_SHIFT_HI;
            sck_n   = 1'b1;
            capture = 1'b1;
          end else begin
            state_n  = ST_HOLD;
            cs_n     = 1'b1;
            sample_n = shreg;
            valid_n  = 1'b1;
            gen_load = 1'b1;
            gen_val  = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    // Lead bits arrive while more than DATA_BITS remain and never reach the shift register
    if (capture) begin
      bits_n = bits - CNT_W'(1);
      if (bits <= DATA_LAST) begin
        shreg_n = {shreg[10:0], sdi};
      end
    end
  end

  // State and output registers; reset abandons any partial frame without a valid pulse
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state        <= ST_IDLE;
      cs           <= 1'b1;
      sck          <= 1'b0;
      bits         <= '0;
      shreg        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cs           <= cs_n;
      sck          <= sck_n;
      bits         <= bits_n;
      shreg        <= shreg_n;
      sample       <= sample_n;
      sample_valid <= valid_n;
    end
  end

  assign busy         = (state != ST_IDLE);
  assign debug_states = state;

endmodule

// File: tb/tb_adc_12bit_spi.sv
// tb/tb_adc_12bit_spi.sv - self-checking bench for adc_12bit_spi
module tb_adc_12bit_spi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default parameters
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic        cs_a, sck_a, sample_valid_a, busy_a;
  logic [11:0] sample_a;
  logic [3:0]  debug_states_a;
  wire         sdi_a;
  logic [13:0] word_a = '0;
  int          pos_a = 0;

  // Instance B: fastest timing, no lead bits
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic        cs_b, sck_b, sample_valid_b, busy_b;
  logic [11:0] sample_b;
  logic [3:0]  debug_states_b;
  wire         sdi_b;
  logic [11:0] word_b = '0;
  int          pos_b = 0;

  adc_12bit_spi dut_a (
    .clk12MHz     (clk),
    .rst          (rst_a),
    .start        (start_a),
    .sdi          (sdi_a),
    .cs           (cs_a),
    .sck          (sck_a),
    .sample       (sample_a),
    .sample_valid (sample_valid_a),
    .busy         (busy_a),
    .debug_states (debug_states_a)
  );

  adc_12bit_spi #(
    .SCK_DIV   (1),
    .CS_SETUP  (1),
    .CS_IDLE   (6),
    .LEAD_BITS (0)
  ) dut_b (
    .clk12MHz     (clk),
    .rst          (rst_b),
    .start        (start_b),
    .sdi          (sdi_b),
    .cs           (cs_b),
    .sck          (sck_b),
    .sample       (sample_b),
    .sample_valid (sample_valid_b),
    .busy         (busy_b),
    .debug_states (debug_states_b)
  );

  // ADC models: first bit presented while cs is low, next bit after each sck fall
  always @(posedge cs_a or negedge sck_a) if (cs_a) pos_a = 0; else pos_a = pos_a + 1;
  assign sdi_a = (pos_a < 14) ? word_a[4'(13 - pos_a)] : 1'b0;
  always @(posedge cs_b or negedge sck_b) if (cs_b) pos_b = 0; else pos_b = pos_b + 1;
  assign sdi_b = (pos_b < 12) ? word_b[4'(11 - pos_b)] : 1'b0;

  // Event monitors, sampled on the falling clock edge
  int          rises_a = 0, rises_b = 0;
  int          fall_a[$], rise_a[$], vcyc_a[$], fall_b[$], vcyc_b[$];
  logic [11:0] vval_a[$], vval_b[$];
  logic        pcs_a = 1'b1, psck_a = 1'b0, pcs_b = 1'b1, psck_b = 1'b0;

  always @(negedge clk) begin
    if (pcs_a === 1'b1 && cs_a === 1'b0) fall_a.push_back(cyc);
    if (pcs_a === 1'b0 && cs_a === 1'b1) rise_a.push_back(cyc);
    if (psck_a === 1'b0 && sck_a === 1'b1 && cs_a === 1'b0) rises_a++;
    if (sample_valid_a === 1'b1) begin vcyc_a.push_back(cyc); vval_a.push_back(sample_a); end
    pcs_a = cs_a; psck_a = sck_a;
    if (pcs_b === 1'b1 && cs_b === 1'b0) fall_b.push_back(cyc);
    if (psck_b === 1'b0 && sck_b === 1'b1 && cs_b === 1'b0) rises_b++;
    if (sample_valid_b === 1'b1) begin vcyc_b.push_back(cyc); vval_b.push_back(sample_b); end
    pcs_b = cs_b; psck_b = sck_b;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic frame_a(input logic [13:0] w, output int lat, output int nr, output int np,
                         output logic [11:0] val);
    int f0, v0, r0;
    word_a = w; f0 = fall_a.size(); v0 = vcyc_a.size(); r0 = rises_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (vcyc_a.size() != v0) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    nr = rises_a - r0; np = vcyc_a.size() - v0;
    if (np > 0 && fall_a.size() > f0) begin lat = vcyc_a[v0] - fall_a[f0]; val = vval_a[v0]; end
    else begin lat = -1; val = 'x; end
  endtask

  task automatic frame_b(input logic [11:0] w, output int lat, output int nr, output int np,
                         output logic [11:0] val);
    int f0, v0, r0;
    word_b = w; f0 = fall_b.size(); v0 = vcyc_b.size(); r0 = rises_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (vcyc_b.size() != v0) break;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    nr = rises_b - r0; np = vcyc_b.size() - v0;
    if (np > 0 && fall_b.size() > f0) begin lat = vcyc_b[v0] - fall_b[f0]; val = vval_b[v0]; end
    else begin lat = -1; val = 'x; end
  endtask

  typedef struct packed {
    logic [1:0]  lead;
    logic [11:0] data;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, nr, np, f0, v0, r0, lead;
    logic [11:0] val, d, exp_s;
    logic [13:0] w;

    vecs[0] = '{2'b00, 12'hA5C, 12'hA5C};
    vecs[1] = '{2'b11, 12'h001, 12'h001};
    vecs[2] = '{2'b00, 12'hFFF, 12'hFFF};
    vecs[3] = '{2'b11, 12'h000, 12'h000};
    vecs[4] = '{2'b10, 12'h800, 12'h800};

    // Reset state
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check("reset cs", cs_a, 1);
    check("reset sck", sck_a, 0);
    check("reset sample", sample_a, 0);
    check("reset valid", sample_valid_a, 0);
    check("reset busy", busy_a, 0);
    check("reset debug_states", debug_states_a, 0);
    @(negedge clk);

    // Fixed vectors
    for (int i = 0; i < 5; i++) begin
      frame_a({vecs[i].lead, vecs[i].data}, lat, nr, np, val);
      check($sformatf("vec%0d sample", i), val, vecs[i].exp);
      check($sformatf("vec%0d valid latency", i), lat, 87);
      check($sformatf("vec%0d sck rises", i), nr, 14);
      check($sformatf("vec%0d valid pulses", i), np, 1);
    end

    // Random frames: the sample is the 12 bits that follow the lead bits on the wire
    for (int i = 0; i < 8; i++) begin
      lead  = int'($urandom_range(0, 3));
      d     = 12'($urandom_range(0, 4095));
      w     = 14'(lead * 4096 + int'(d));
      exp_s = 12'(int'(w) % 4096);
      frame_a(w, lat, nr, np, val);
      check($sformatf("rand%0d sample", i), val, exp_s);
      check($sformatf("rand%0d valid latency", i), lat, 87);
    end

    // Back-to-back frames with start held high
    word_a = {2'b01, 12'h123};
    f0 = fall_a.size(); v0 = vcyc_a.size(); r0 = rise_a.size();
    start_a = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (vcyc_a.size() >= v0 + 2) break;
      if (vcyc_a.size() == v0 + 1) word_a = {2'b10, 12'hABC};
      @(negedge clk);
    end
    start_a = 1'b0;
    repeat (12) @(negedge clk);
    if (vcyc_a.size() >= v0 + 2 && fall_a.size() >= f0 + 2 && rise_a.size() >= r0 + 1) begin
      check("b2b cs fall spacing", fall_a[f0+1] - fall_a[f0], 94);
      check("b2b cs high cycles", fall_a[f0+1] - rise_a[r0], 7);
      check("b2b valid1 latency", vcyc_a[v0] - fall_a[f0], 87);
      check("b2b valid2 latency", vcyc_a[v0+1] - fall_a[f0], 181);
      check("b2b sample1", vval_a[v0], 12'h123);
      check("b2b sample2", vval_a[v0+1], 12'hABC);
      check("b2b frame count", fall_a.size() - f0, 2);
    end else begin
      check("b2b frames seen", vcyc_a.size() - v0, 2);
    end

    // Start while busy is ignored
    word_a = {2'b00, 12'h3C3};
    f0 = fall_a.size(); v0 = vcyc_a.size();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (19) @(negedge clk);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (120) @(negedge clk);
    check("busy-start frames", fall_a.size() - f0, 1);
    check("busy-start valids", vcyc_a.size() - v0, 1);
    check("busy-start cs idle", cs_a, 1);
    check("busy-start busy idle", busy_a, 0);
    check("busy-start sample", sample_a, 12'h3C3);

    // Reset in the middle of a frame at E+40
    word_a = {2'b11, 12'h7E1};
    v0 = vcyc_a.size();
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    repeat (39) @(negedge clk);
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    check("midreset cs", cs_a, 1);
    check("midreset sck", sck_a, 0);
    check("midreset sample", sample_a, 0);
    check("midreset busy", busy_a, 0);
    check("midreset debug_states", debug_states_a, 0);
    repeat (120) @(negedge clk);
    check("midreset no valid", vcyc_a.size() - v0, 0);
    frame_a({2'b01, 12'h456}, lat, nr, np, val);
    check("postreset sample", val, 12'h456);
    check("postreset latency", lat, 87);
    check("postreset sck rises", nr, 14);

    // Parameter sweep instance
    frame_b(12'h5A5, lat, nr, np, val);
    check("sweep sample", val, 12'h5A5);
    check("sweep valid latency", lat, 25);
    check("sweep sck rises", nr, 12);
    check("sweep valid pulses", np, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
